mem_access_sequencer: RTL and testbench
=======================================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum number of WAIT cycles before the request is aborted.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_valid / host_ready  in / out  1 / 1  host request handshake.
- host_addr / host_wdata / host_we  in  ADDR_WIDTH / DATA_WIDTH / 1  host request fields.
- prx_valid / prx_ready  in / out  1 / 1  proxy request handshake.
- prx_addr / prx_wdata / prx_we  in  ADDR_WIDTH / DATA_WIDTH / 1  proxy request fields.
- win_lo / win_hi  in  ADDR_WIDTH each  inclusive address window in which proxy access is permitted.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_src  out  1  source of the response: 0 = host, 1 = proxy.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  error flag: denied or timed out.
- mem_start  out  1  one-cycle start pulse to the downstream memory.
- mem_address / mem_write_data / mem_write_enable  out  ADDR_WIDTH / DATA_WIDTH / 1  downstream request fields.
- mem_ready  in  1  downstream ready (sticky high after a start).
- mem_read_data  in  DATA_WIDTH  downstream read data.
- denied_count  out  8  saturating count of denied proxy requests.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-006 In IDLE, host_ready SHALL equal grant_host and prx_ready SHALL equal grant_prx, with both forced to 0 in every other state.
REQ-007 Arbitration SHALL grant the sole valid requester; when both are valid it SHALL grant round-robin, opposite to the last granted source.
REQ-008 On accept (valid and ready), the block SHALL latch addr, wdata, we and src, and update the last-grant pointer.
REQ-009 A proxy request SHALL be denied if its addr < win_lo, its addr > win_hi, or win_lo > win_hi; host requests SHALL never be denied.
REQ-010 A denied request SHALL go IDLE -> RESP with rsp_err=1 and rsp_rdata=0, SHALL NOT assert mem_start, and SHALL increment denied_count, saturating at 255.
REQ-011 A permitted request SHALL go IDLE -> ISSUE, in which mem_start=1 for exactly one cycle with mem_address, mem_write_data and mem_write_enable driven from the latched fields.
REQ-012 ISSUE SHALL go to WAIT unconditionally; the mem_* fields SHALL stay stable through WAIT; mem_start SHALL be 0 outside ISSUE.
REQ-013 In WAIT, mem_ready=1 SHALL capture mem_read_data into rsp_rdata, set rsp_err=0 and go to RESP; the rdata is captured for writes as well.
REQ-014 The WAIT counter SHALL start at 0 on entry; if mem_ready is still 0 when the counter reaches TIMEOUT-1, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-015 In RESP, rsp_valid=1 SHALL hold, with rsp_src, rsp_rdata and rsp_err stable, until rsp_ready=1; RESP SHALL then go to IDLE with rsp_valid=0 on the next cycle.
REQ-016 Latency for a permitted request with immediate mem_ready: accept at edge N, mem_start high in cycle N+1, rsp_valid high from cycle N+3.
REQ-017 Latency for a denied request: rsp_valid high from cycle N+1 after the accept at edge N.
REQ-018 Only one request SHALL be outstanding at a time; no new accept SHALL occur until the response handshake completes.
REQ-019 Requests not granted SHALL wait, with valid held by the requester; the block SHALL NOT drop them.

Reset
REQ-020 While reset_n=0, the block SHALL force state=IDLE, the pointer to favour host first, and mem_start, rsp_valid, rsp_err, rsp_src, rsp_rdata, mem_* outputs and denied_count all to 0.
REQ-021 Reset asserted mid-operation SHALL abort the transaction with no response and no further mem_start.
REQ-022 After reset release, the block SHALL accept a request on the first clock edge at which a requester is valid.

Verification
REQ-023 Host read at addr 0x10, with mem_ready high the cycle after start and mem_read_data=0xDEADBEEF -> one mem_start pulse; rsp_valid at N+3 with rdata=0xDEADBEEF, err=0, src=0.
REQ-024 Window win_lo=0x20, win_hi=0x2F; proxy write to 0x30 -> no mem_start, rsp err=1, rdata=0, denied_count=1; a proxy write to 0x25 -> mem_start with mem_write_enable=1, err=0.
REQ-025 host_valid and prx_valid held high, proxy addresses in window, rsp_ready=1 -> grants alternate host, proxy, host, proxy.
REQ-026 mem_ready tied to 0, TIMEOUT=16 -> rsp err=1 after 16 WAIT cycles; the FSM then returns to IDLE and the next request is accepted.
REQ-027 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable and host_ready/prx_ready=0 throughout.
REQ-028 win_lo=0x40, win_hi=0x10 -> every proxy request is denied; reset_n pulsed during WAIT -> no rsp_valid and all outputs at 0.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Arbitrates host and proxy requests onto a single downstream memory port,
// applies the proxy address window, and returns one response per request.
module mem_access_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_we,
  input  logic                  prx_valid,
  output logic                  prx_ready,
  input  logic [ADDR_WIDTH-1:0] prx_addr,
  input  logic [DATA_WIDTH-1:0] prx_wdata,
  input  logic                  prx_we,
  input  logic [ADDR_WIDTH-1:0] win_lo,
  input  logic [ADDR_WIDTH-1:0] win_hi,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_src,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [7:0]            denied_count,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid must be held with stable fields until then, and ready never
  // waits on anything but the FSM state and the other requester's valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  logic            last_prx;
  logic [CW-1:0]   wait_cnt;
  logic            grant_host;
  logic            grant_prx;
  logic            accept;
  logic            deny;

  // last_prx resets to 1 so that a tie right after reset goes to the host.
  assign grant_host = host_valid && (!prx_valid || last_prx);
  assign grant_prx  = prx_valid && (!host_valid || !last_prx);
  assign accept     = (state == IDLE) && (grant_host || grant_prx);
  assign deny       = grant_prx &&
                      ((prx_addr < win_lo) || (prx_addr > win_hi) || (win_lo > win_hi));
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    host_ready = 1'b0;
    prx_ready  = 1'b0;
    mem_start  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        host_ready = grant_host;
        prx_ready  = grant_prx;
        if (grant_host || grant_prx) begin
          next_state = deny ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (mem_ready || (wait_cnt == WAIT_LAST)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields double as the downstream outputs, so they stay put until
  // the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_prx         <= 1'b1;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      rsp_src          <= 1'b0;
      rsp_rdata        <= '0;
      rsp_err          <= 1'b0;
      denied_count     <= 8'd0;
      wait_cnt         <= '0;
    end else begin
      if (accept) begin
        mem_address      <= grant_host ? host_addr  : prx_addr;
        mem_write_data   <= grant_host ? host_wdata : prx_wdata;
        mem_write_enable <= grant_host ? host_we    : prx_we;
        rsp_src          <= !grant_host;
        last_prx         <= !grant_host;
        if (deny) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          if (denied_count != 8'hFF) begin
            denied_count <= denied_count + 8'd1;
          end
        end
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (mem_ready) begin
          rsp_rdata <= mem_read_data;
          rsp_err   <= 1'b0;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: a behavioural downstream memory,
// a response scoreboard and latency/arbitration/reset checks.
module tb_mem_access_sequencer;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;
  localparam int RW = DW + 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          host_valid, host_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          prx_valid, prx_ready, prx_we;
  logic [AW-1:0] prx_addr;
  logic [DW-1:0] prx_wdata;
  logic [AW-1:0] win_lo, win_hi;
  logic          rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_start, mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic [7:0]    denied_count;
  logic [1:0]    dbg_state;

  mem_access_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_we(host_we),
    .prx_valid(prx_valid), .prx_ready(prx_ready), .prx_addr(prx_addr),
    .prx_wdata(prx_wdata), .prx_we(prx_we),
    .win_lo(win_lo), .win_hi(win_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_start(mem_start), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_ready(mem_ready),
    .mem_read_data(mem_read_data), .denied_count(denied_count), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            n_asserts = 0;
  int            n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem [256];
  bit            exp_wr [256];
  logic [7:0]    denied_model = 8'd0;
  bit            last_prx_model = 1'b1;
  bit            mem_auto = 1'b1;

  // Downstream memory: returns the pre-write contents, ready stays sticky.
  logic [DW-1:0] dev_mem [256];
  bit            dev_wr [256];
  int            start_count = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {a, ~a, 8'hC3, a ^ 8'h5A};
  endfunction

  always @(negedge clk) begin
    if (mem_start) begin
      start_count++;
      mem_ready     = mem_auto;
      mem_read_data = dev_wr[mem_address] ? dev_mem[mem_address] : init_word(mem_address);
      if (mem_write_enable) begin
        dev_mem[mem_address] = mem_write_data;
        dev_wr[mem_address]  = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit src, input logic [AW-1:0] addr, input bit we,
                          input logic [DW-1:0] wdata);
    bit            denied;
    bit            err;
    logic [DW-1:0] rd;
    denied = src && ((addr < win_lo) || (addr > win_hi) || (win_lo > win_hi));
    err    = denied || !mem_auto;
    rd     = err ? '0 : (exp_wr[addr] ? exp_mem[addr] : init_word(addr));
    if (!denied && we) begin
      exp_mem[addr] = wdata;
      exp_wr[addr]  = 1'b1;
    end
    if (denied && denied_model != 8'hFF) denied_model++;
    exp_q.push_back({src, err, rd});
  endtask

  // Driver: present a request at a falling edge, hold it until accepted.
  task automatic drive_req(input bit src, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input bit we);
    bit got = 1'b0;
    if (src) begin
      prx_addr = addr; prx_wdata = wdata; prx_we = we; prx_valid = 1'b1;
    end else begin
      host_addr = addr; host_wdata = wdata; host_we = we; host_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((src ? prx_ready : host_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", got, 1);
    if (got) begin
      push_exp(src, addr, we, wdata);
      last_prx_model = src;
      @(negedge clk);
    end
    if (src) prx_valid = 1'b0;
    else host_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit            seen = 1'b0;
    logic [RW-1:0] e;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, seen, 1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        n_asserts++;
        n_fail++;
        $error("FAIL %s_unexpected observed=response expected=none", tag);
      end else begin
        e = exp_q.pop_front();
        check(tag, {rsp_src, rsp_err, rsp_rdata}, e);
      end
      if (rsp_ready) @(negedge clk);
    end
  endtask

  task automatic do_req(input bit src, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit we, input string tag);
    drive_req(src, addr, wdata, we);
    wait_rsp(tag);
  endtask

  initial begin
    int            s0;
    int            cnt;
    logic [DW-1:0] w;
    logic [3:0]    gseq;
    bit            g;
    logic [AW-1:0] bnd [4];

    reset_n = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_wdata = '0; host_we = 1'b0;
    prx_valid = 1'b0;  prx_addr = '0;  prx_wdata = '0;  prx_we = 1'b0;
    win_lo = 8'h20; win_hi = 8'h2F; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_state", dbg_state, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_src, rsp_rdata}, 0);
    check("rst_mem", {mem_start, mem_write_enable, mem_address, mem_write_data}, 0);
    check("rst_denied", denied_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Host read at 0x10, ready the cycle after start.
    s0 = start_count;
    host_addr = 8'h10; host_we = 1'b0; host_wdata = '0; host_valid = 1'b1;
    #1 check("t23_ready", host_ready, 1);
    push_exp(1'b0, 8'h10, 1'b0, '0);
    last_prx_model = 1'b0;
    @(negedge clk);
    host_valid = 1'b0;
    check("t23_start_n1", {mem_start, rsp_valid}, 2'b10);
    check("t23_addr", {mem_write_enable, mem_address}, {1'b0, 8'h10});
    @(negedge clk);
    check("t23_n2", {mem_start, rsp_valid, mem_address}, {2'b00, 8'h10});
    @(negedge clk);
    check("t23_valid_n3", rsp_valid, 1);
    wait_rsp("t23_rsp");
    #1 check("t23_one_start", start_count - s0, 1);

    // Out-of-window proxy write is denied without touching memory.
    @(negedge clk);
    s0 = start_count;
    w = $urandom;
    prx_addr = 8'h30; prx_wdata = w; prx_we = 1'b1; prx_valid = 1'b1;
    #1 check("t24_ready", prx_ready, 1);
    push_exp(1'b1, 8'h30, 1'b1, w);
    last_prx_model = 1'b1;
    @(negedge clk);
    prx_valid = 1'b0;
    check("t24_deny_n1", {rsp_valid, mem_start}, 2'b10);
    wait_rsp("t24_deny");
    #1 check("t24_no_start", start_count - s0, 0);
    check("t24_denied_cnt", denied_count, 1);

    @(negedge clk);
    w = $urandom;
    drive_req(1'b1, 8'h25, w, 1'b1);
    check("t24_wr_start", {mem_start, mem_write_enable, mem_address}, {2'b11, 8'h25});
    check("t24_wr_data", mem_write_data, w);
    wait_rsp("t24_wr_rsp");
    do_req(1'b0, 8'h25, '0, 1'b0, "t24_readback");

    // Mixed traffic around the window, then its exact edges.
    for (int i = 0; i < 10; i++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(8'h1C, 8'h33)),
             $urandom, 1'($urandom_range(0, 1)), "mix");
    end
    bnd = '{8'h1F, 8'h20, 8'h2F, 8'h30};
    foreach (bnd[i]) do_req(1'b1, bnd[i], '0, 1'b0, "bound");
    check("denied_track", denied_count, denied_model);

    // Both requesters held valid: grants alternate host, proxy, ...
    host_addr = 8'h11; host_we = 1'b0; host_valid = 1'b1;
    prx_addr = 8'h22;  prx_we = 1'b0;  prx_valid = 1'b1;
    gseq = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = !last_prx_model;
      gseq[k] = prx_ready;
      check("t25_grant", {host_ready, prx_ready}, {!g, g});
      push_exp(g, g ? 8'h22 : 8'h11, 1'b0, '0);
      last_prx_model = g;
      @(negedge clk);
      wait_rsp("t25_rsp");
    end
    host_valid = 1'b0; prx_valid = 1'b0;
    check("t25_order", gseq, 4'b1010);

    // Response back-pressure: fields hold, no new grants.
    rsp_ready = 1'b0;
    drive_req(1'b0, 8'h12, '0, 1'b0);
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) @(negedge clk);
    host_valid = 1'b1; prx_addr = 8'h23; prx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t27_hold", {rsp_valid, rsp_src, rsp_err, rsp_rdata}, {1'b1, exp_q[0]});
      check("t27_no_ready", {host_ready, prx_ready}, 2'b00);
    end
    host_valid = 1'b0; prx_valid = 1'b0; rsp_ready = 1'b1;
    wait_rsp("t27_rsp");

    // Downstream never ready: abort after TIMEOUT wait cycles.
    mem_auto = 1'b0;
    drive_req(1'b0, 8'h13, '0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      cnt++;
    end
    check("t26_wait_cycles", cnt, TO);
    wait_rsp("t26_timeout");
    mem_auto = 1'b1;
    do_req(1'b0, 8'h14, '0, 1'b0, "t26_next");

    // Inverted window denies every proxy address.
    win_lo = 8'h40; win_hi = 8'h10;
    do_req(1'b1, 8'h10, '0, 1'b0, "t28_inv");
    do_req(1'b1, 8'h40, '0, 1'b1, "t28_inv");
    for (int i = 0; i < 4; i++) do_req(1'b1, 8'($urandom_range(0, 255)), $urandom, 1'b0, "t28_inv");
    check("t28_denied_cnt", denied_count, denied_model);

    // Saturation of the denied counter.
    win_lo = 8'h20; win_hi = 8'h2F;
    for (int i = 0; i < 250; i++) do_req(1'b1, 8'h00, '0, 1'b0, "sat");
    check("sat_count", denied_count, 8'hFF);

    // Reset in WAIT: transaction dropped, everything back to zero.
    mem_auto = 1'b0;
    drive_req(1'b0, 8'h15, '0, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("t28_in_wait", dbg_state, 2);
    reset_n = 1'b0;
    #1;
    check("t28_rst_rsp", {rsp_valid, rsp_err, rsp_src, rsp_rdata}, 0);
    check("t28_rst_mem", {mem_start, mem_write_enable, mem_address, mem_write_data}, 0);
    check("t28_rst_misc", {dbg_state, denied_count}, 0);
    denied_model = 8'd0;
    last_prx_model = 1'b1;
    mem_auto = 1'b1;
    s0 = start_count;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t28_quiet", {rsp_valid, mem_start}, 2'b00);
    end
    #1 check("t28_no_start", start_count - s0, 0);

    // Both valid at the first edge after release: host first, then proxy.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    host_addr = 8'h16; host_we = 1'b0; host_valid = 1'b1;
    prx_addr = 8'h24;  prx_we = 1'b0;  prx_valid = 1'b1;
    reset_n = 1'b1;
    #1 check("t22_first", {host_ready, prx_ready}, 2'b10);
    push_exp(1'b0, 8'h16, 1'b0, '0);
    @(negedge clk);
    host_valid = 1'b0;
    check("t22_start", mem_start, 1);
    wait_rsp("t22_host");
    #1 check("t22_prx_ready", prx_ready, 1);
    push_exp(1'b1, 8'h24, 1'b0, '0);
    @(negedge clk);
    prx_valid = 1'b0;
    wait_rsp("t22_prx");
    check("q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
